// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit queue, tag = entry index, CDB capture, one retire per cycle.
// Optional macro ROB_FWD_EN adds combinational lookup of completed, uncommitted results.
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [WIDTH-1:0] cdb_data,
   output logic             commit_rdy,
   output logic [TAG_W-1:0] commit_tag,
   output logic [4:0]       commit_rd,
   output logic [WIDTH-1:0] commit_data,
   input  logic [TAG_W-1:0] fwd_tag1,
   input  logic [TAG_W-1:0] fwd_tag2,
   output logic             fwd_hit1,
   output logic             fwd_hit2,
   output logic [WIDTH-1:0] fwd_data1,
   output logic [WIDTH-1:0] fwd_data2
);

   typedef struct packed {
      logic             valid;
      logic             ready;
      logic [4:0]       rd;
      logic [WIDTH-1:0] data;
   } rob_entry_t;

   localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

   rob_entry_t       ent [DEPTH];
   rob_entry_t       head_ent;
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;
   logic             do_alloc;
   logic             do_commit;
   logic             cdb_hit;

   assign head_ent    = ent[head];
   assign alloc_ready = count < CNT_FULL;
   assign alloc_tag   = tail;
   assign do_alloc    = alloc_valid & alloc_ready;
   assign do_commit   = head_ent.valid & head_ent.ready;
   assign cdb_hit     = cdb_valid & ent[cdb_tag].valid;

   // alloc never targets a valid slot, so it cannot collide with a CDB write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         if (cdb_hit) begin
            ent[cdb_tag].ready <= 1'b1;
            ent[cdb_tag].data  <= cdb_data;
         end
         if (do_commit) ent[head].valid <= 1'b0;
         if (do_alloc) begin
            ent[tail].valid <= 1'b1;
            ent[tail].ready <= 1'b0;
            ent[tail].rd    <= alloc_rd;
            ent[tail].data  <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_alloc) tail <= tail + TAG_W'(1);
         if (do_commit) head <= head + TAG_W'(1);
         unique case (1'b1)
            do_alloc & ~do_commit: count <= count + (TAG_W+1)'(1);
            do_commit & ~do_alloc: count <= count - (TAG_W+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_rdy  <= 1'b0;
         commit_tag  <= '0;
         commit_rd   <= '0;
         commit_data <= '0;
      end else begin
         commit_rdy <= do_commit;
         if (do_commit) begin
            commit_tag  <= head;
            commit_rd   <= head_ent.rd;
            commit_data <= head_ent.data;
         end
      end
   end

`ifdef ROB_FWD_EN
   rob_entry_t fwd_ent1;
   rob_entry_t fwd_ent2;

   assign fwd_ent1  = ent[fwd_tag1];
   assign fwd_ent2  = ent[fwd_tag2];
   assign fwd_hit1  = fwd_ent1.valid & fwd_ent1.ready;
   assign fwd_hit2  = fwd_ent2.valid & fwd_ent2.ready;
   assign fwd_data1 = fwd_ent1.data;
   assign fwd_data2 = fwd_ent2.data;
`else
   logic unused_fwd;

   assign unused_fwd = ^{fwd_tag1, fwd_tag2};
   assign fwd_hit1   = 1'b0;
   assign fwd_hit2   = 1'b0;
   assign fwd_data1  = '0;
   assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the commit queue.
module tb_reorder_buffer;
   localparam int DEPTH = 16;
   localparam int TAG_W = 4;
   localparam int WIDTH = 32;
`ifdef ROB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             alloc_valid = 1'b0;
   logic [4:0]       alloc_rd = '0;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             cdb_valid = 1'b0;
   logic [TAG_W-1:0] cdb_tag = '0;
   logic [WIDTH-1:0] cdb_data = '0;
   logic             commit_rdy;
   logic [TAG_W-1:0] commit_tag;
   logic [4:0]       commit_rd;
   logic [WIDTH-1:0] commit_data;
   logic [TAG_W-1:0] fwd_tag1 = '0;
   logic [TAG_W-1:0] fwd_tag2 = '0;
   logic             fwd_hit1;
   logic             fwd_hit2;
   logic [WIDTH-1:0] fwd_data1;
   logic [WIDTH-1:0] fwd_data2;

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .commit_rdy(commit_rdy), .commit_tag(commit_tag),
      .commit_rd(commit_rd), .commit_data(commit_data),
      .fwd_tag1(fwd_tag1), .fwd_tag2(fwd_tag2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic [31:0] data;
      bit          rdy;
   } ent_t;

   typedef struct {
      bit          av;
      logic [4:0]  ard;
      bit          cv;
      logic [3:0]  ct;
      logic [31:0] cd;
      bit          e_rdy;
      logic [3:0]  e_tag;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic [3:0]  e_atag;
   } tv_t;

   ent_t        q[$];
   int          tail_m;
   bit          m_crdy;
   logic [3:0]  m_ctag;
   logic [4:0]  m_crd;
   logic [31:0] m_cdata;
   int          n_chk = 0;
   int          n_fail = 0;
   tv_t         tv [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      tail_m  = 0;
      m_crdy  = 0;
      m_ctag  = '0;
      m_crd   = '0;
      m_cdata = '0;
   endtask

   task automatic idle();
      alloc_valid = 1'b0;
      cdb_valid   = 1'b0;
   endtask

   task automatic fwd_expect(input logic [3:0] t, output bit hit, output logic [31:0] d);
      hit = 0;
      d   = '0;
      if (FWD) begin
         foreach (q[i]) if (q[i].tag == t && q[i].rdy) begin
            hit = 1;
            d   = q[i].data;
         end
      end
   endtask

   task automatic check_outputs();
      bit          h;
      logic [31:0] d;
      chk("commit_rdy", commit_rdy, m_crdy);
      chk("commit_tag", commit_tag, m_ctag);
      chk("commit_rd", commit_rd, m_crd);
      chk("commit_data", commit_data, m_cdata);
      chk("alloc_ready", alloc_ready, q.size() < DEPTH);
      chk("alloc_tag", alloc_tag, tail_m);
      fwd_expect(fwd_tag1, h, d);
      chk("fwd_hit1", fwd_hit1, h);
      if (h || !FWD) chk("fwd_data1", fwd_data1, d);
      fwd_expect(fwd_tag2, h, d);
      chk("fwd_hit2", fwd_hit2, h);
      if (h || !FWD) chk("fwd_data2", fwd_data2, d);
   endtask

   // model: commit reads pre-edge head, CDB lands afterwards, alloc appends last
   task automatic step();
      ent_t e;
      bit   fire;
      fire   = alloc_valid && q.size() < DEPTH;
      m_crdy = 0;
      if (q.size() > 0 && q[0].rdy) begin
         m_crdy  = 1;
         m_ctag  = q[0].tag;
         m_crd   = q[0].rd;
         m_cdata = q[0].data;
         void'(q.pop_front());
      end
      if (cdb_valid) begin
         foreach (q[i]) if (q[i].tag == cdb_tag) begin
            q[i].rdy  = 1;
            q[i].data = cdb_data;
         end
      end
      if (fire) begin
         e.tag  = 4'(tail_m);
         e.rd   = alloc_rd;
         e.data = '0;
         e.rdy  = 0;
         q.push_back(e);
         tail_m = (tail_m + 1) % DEPTH;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      tv[0] = '{1, 5, 0, 0, 0,     0, 0, 0, 0,     1};
      tv[1] = '{1, 6, 0, 0, 0,     0, 0, 0, 0,     2};
      tv[2] = '{0, 0, 1, 1, 'hBB,  0, 0, 0, 0,     2};
      tv[3] = '{0, 0, 0, 0, 0,     0, 0, 0, 0,     2};
      tv[4] = '{0, 0, 1, 0, 'hAA,  0, 0, 0, 0,     2};
      tv[5] = '{0, 0, 0, 0, 0,     1, 0, 5, 'hAA,  2};
      tv[6] = '{0, 0, 0, 0, 0,     1, 1, 6, 'hBB,  2};
      tv[7] = '{0, 0, 0, 0, 0,     0, 1, 6, 'hBB,  2};
      tv[8] = '{0, 0, 1, 3, 'h33,  0, 1, 6, 'hBB,  2};
      tv[9] = '{0, 0, 0, 0, 0,     0, 1, 6, 'hBB,  2};

      do_reset();
      #1;
      chk("rst_commit_rdy", commit_rdy, 0);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_tag", alloc_tag, 0);

      for (int i = 0; i < 10; i++) begin
         alloc_valid = tv[i].av;
         alloc_rd    = tv[i].ard;
         cdb_valid   = tv[i].cv;
         cdb_tag     = tv[i].ct;
         cdb_data    = tv[i].cd;
         step();
         chk($sformatf("tv%0d_rdy", i), commit_rdy, tv[i].e_rdy);
         chk($sformatf("tv%0d_tag", i), commit_tag, tv[i].e_tag);
         chk($sformatf("tv%0d_rd", i), commit_rd, tv[i].e_rd);
         chk($sformatf("tv%0d_data", i), commit_data, tv[i].e_data);
         chk($sformatf("tv%0d_atag", i), alloc_tag, tv[i].e_atag);
      end

      // fill to full, try one more, then free a slot
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         alloc_valid = 1'b1;
         alloc_rd    = 5'(i);
         step();
      end
      chk("full_alloc_ready", alloc_ready, 0);
      chk("full_alloc_tag", alloc_tag, 0);
      alloc_rd = 5'd31;
      step();
      chk("full_hold_ready", alloc_ready, 0);
      chk("full_hold_tag", alloc_tag, 0);
      idle();
      cdb_valid = 1'b1;
      cdb_tag   = 4'd0;
      cdb_data  = 32'h55;
      step();
      chk("full_no_early", commit_rdy, 0);
      idle();
      step();
      chk("full_commit", commit_rdy, 1);
      chk("full_free_ready", alloc_ready, 1);
      chk("full_wrap_tag", alloc_tag, 0);
      alloc_valid = 1'b1;
      alloc_rd    = 5'd9;
      step();
      chk("full_refill_tag", alloc_tag, 1);
      chk("full_refill_ready", alloc_ready, 0);

      // steady state: alloc + CDB of previous + commit of head every cycle
      do_reset();
      for (int i = 0; i < 22; i++) begin
         alloc_valid = 1'b1;
         alloc_rd    = 5'(i);
         cdb_valid   = (i > 0);
         cdb_tag     = 4'(tail_m - 1);
         cdb_data    = 32'h100 + 32'(i);
         step();
         if (i >= 2) begin
            chk("steady_commit", commit_rdy, 1);
            chk("steady_ready", alloc_ready, 1);
            chk("steady_count", q.size(), 2);
         end
      end

      // forwarding lookup
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         alloc_valid = 1'b1;
         alloc_rd    = 5'(i);
         step();
      end
      idle();
      fwd_tag1  = 4'd2;
      cdb_valid = 1'b1;
      cdb_tag   = 4'd2;
      cdb_data  = 32'h1234;
      step();
      chk("fwd_hit_ready", fwd_hit1, FWD);
      chk("fwd_data_ready", fwd_data1, FWD ? 32'h1234 : 32'h0);
      cdb_tag = 4'd0;
      step();
      cdb_tag = 4'd1;
      step();
      idle();
      step();
      step();
      chk("fwd_commit_tag", commit_tag, 2);
      chk("fwd_hit_after", fwd_hit1, 0);

      // random traffic with an asynchronous reset in the middle
      do_reset();
      for (int c = 0; c < 800; c++) begin
         alloc_valid = ($urandom_range(99) < 60);
         alloc_rd    = 5'($urandom);
         cdb_valid   = ($urandom_range(99) < 70);
         if (q.size() > 0 && $urandom_range(99) < 80)
            cdb_tag = q[$urandom_range(q.size() - 1)].tag;
         else
            cdb_tag = 4'($urandom);
         cdb_data = $urandom;
         fwd_tag1 = (q.size() > 0) ? q[$urandom_range(q.size() - 1)].tag : 4'($urandom);
         fwd_tag2 = 4'($urandom);
         if (c == 400) begin
            #3;
            rst = 1'b0;
            #1;
            chk("midrst_commit_rdy", commit_rdy, 0);
            chk("midrst_alloc_ready", alloc_ready, 1);
            chk("midrst_alloc_tag", alloc_tag, 0);
            @(posedge clk);
            #1;
            chk("midrst_hold_rdy", commit_rdy, 0);
            idle();
            @(negedge clk);
            rst = 1'b1;
            model_reset();
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
